main_mem_block_ctrl: RTL

MAIN_MEM_BLOCK_CTRL -- requirements
Module: main_mem_block_ctrl

---
 rtl/main_mem_block_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/main_mem_block_ctrl.sv
// Block-granular main memory: 16-beat write-back and refill bursts with a fixed read latency.
// Define MEM_CRITICAL_WORD_FIRST_EN to start refill bursts at the requested word.
module main_mem_block_ctrl #(
    parameter int MEM_SIZE     = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 4,
    parameter int LATENCY      = 4,
    localparam int ADDR_WIDTH  = $clog2(MEM_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_block_addr,
    input  logic [OFFSET_WIDTH-1:0] req_word,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_done,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [OFFSET_WIDTH-1:0] rd_word_idx,
    output logic                    rd_last
);

    localparam int WordsPerBlock = 2 ** OFFSET_WIDTH;
    localparam int Depth         = MEM_SIZE * WordsPerBlock;
    localparam logic [OFFSET_WIDTH-1:0] LastBeat   = '1;
    localparam logic [OFFSET_WIDTH-1:0] PenultBeat = LastBeat - 1'b1;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    localparam bit CritWordFirst = 1'b1;
`else
    localparam bit CritWordFirst = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StWrBurst, StWait, StRdBurst} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   blk_q, blk_d;
    logic [OFFSET_WIDTH-1:0] word_q, word_d;
    logic [3:0]              lat_q, lat_d;
    logic [OFFSET_WIDTH-1:0] wbeat_q, wbeat_d;
    logic [OFFSET_WIDTH-1:0] rbeat_q, rbeat_d;
    logic [OFFSET_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    wr_done_q, wr_done_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    mem_we, rd_load, rd_clear;
    logic [OFFSET_WIDTH-1:0] start_word;

    logic [DATA_WIDTH-1:0] mem [Depth];

    // Without critical-word-first the latched word is masked off and bursts start at 0.
    assign start_word = word_q & {OFFSET_WIDTH{CritWordFirst}};

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        word_d     = word_q;
        lat_d      = lat_q;
        wbeat_d    = wbeat_q;
        rbeat_d    = rbeat_q;
        rd_idx_d   = rd_idx_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = 1'b0;
        wr_done_d  = 1'b0;
        mem_we     = 1'b0;
        rd_load    = 1'b0;
        rd_clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    blk_d  = req_block_addr;
                    word_d = req_word;
                    if (req_write) begin
                        state_d = StWrBurst;
                        wbeat_d = '0;
                    end else begin
                        state_d = StWait;
                        lat_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWrBurst: begin
                if (wr_valid) begin
                    mem_we  = 1'b1;
                    wbeat_d = wbeat_q + 1'b1;
                    if (wbeat_q == LastBeat) begin
                        state_d   = StIdle;
                        wr_done_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (lat_q == 4'd0) begin
                    state_d    = StRdBurst;
                    rd_load    = 1'b1;
                    rd_idx_d   = start_word;
                    rd_valid_d = 1'b1;
                    rbeat_d    = '0;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StRdBurst: begin
                if (rbeat_q == LastBeat) begin
                    state_d    = StIdle;
                    rd_valid_d = 1'b0;
                    rd_idx_d   = '0;
                    rd_clear   = 1'b1;
                end else begin
                    rd_load   = 1'b1;
                    rd_idx_d  = rd_idx_q + 1'b1;
                    rbeat_d   = rbeat_q + 1'b1;
                    rd_last_d = (rbeat_q == PenultBeat);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            word_q     <= '0;
            lat_q      <= '0;
            wbeat_q    <= '0;
            rbeat_q    <= '0;
            rd_idx_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            word_q     <= word_d;
            lat_q      <= lat_d;
            wbeat_q    <= wbeat_d;
            rbeat_q    <= rbeat_d;
            rd_idx_q   <= rd_idx_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            wr_done_q  <= wr_done_d;
            if (rd_load) begin
                rd_data_q <= mem[{blk_q, rd_idx_d}];
            end else if (rd_clear) begin
                rd_data_q <= '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; reset only blocks new writes.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[{blk_q, wbeat_q}] <= wr_data;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign wr_ready    = (state_q == StWrBurst);
    assign wr_done     = wr_done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_word_idx = rd_idx_q;
    assign rd_last     = rd_last_q;

endmodule
